// File: rtl/adc_chain_max11040_spi_slave.sv
// Responder model of a chain of MAX11040 ADCs as seen on the SPI/DRDY pins.
// Accepts configuration writes, answers register and sample-data reads, and
// produces periodic DRDYOUT_l frames. Register contents are exported for debug.
module adc_chain_max11040_spi_slave #(
    parameter int ADC_DCN       = 8,
    parameter int SAMPLE_PERIOD = 5000,
    parameter int DRDY_PULSE    = 16
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    input  logic                   SCLK,
    input  logic                   CS_l,
    input  logic                   MOSI,
    output logic                   MISO,
    output logic                   DRDYOUT_l,
    output logic [ADC_DCN*8-1:0]   wcr_reg,
    output logic [15:0]            wdrcr_reg,
    output logic [ADC_DCN*32-1:0]  wsicr_reg,
    output logic [15:0]            frame_cnt,
    output logic                   cfg_wr_done_hp,
    output logic                   proto_err_hp
);
    localparam int WCR_W  = ADC_DCN * 8;
    localparam int SICR_W = ADC_DCN * 32;
    localparam int DATA_W = ADC_DCN * 96;
    localparam int CNT_W  = $clog2(DATA_W + 1);
    localparam int PER_W  = $clog2(SAMPLE_PERIOD);
    localparam int DP_W   = $clog2(DRDY_PULSE);
    localparam logic [PER_W-1:0] P_LAST  = PER_W'(SAMPLE_PERIOD - 1);
    localparam logic [DP_W-1:0]  DP_LOAD = DP_W'(DRDY_PULSE - 1);

    localparam logic [7:0] CMD_WCR   = 8'h60;
    localparam logic [7:0] CMD_RCR   = 8'hE0;
    localparam logic [7:0] CMD_WDRCR = 8'h50;
    localparam logic [7:0] CMD_RDRCR = 8'hD0;
    localparam logic [7:0] CMD_WSICR = 8'h40;
    localparam logic [7:0] CMD_RSICR = 8'hC0;
    localparam logic [7:0] CMD_RDATA = 8'hF0;

    typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_WR, ST_RD, ST_IGN} state_t;
    typedef enum logic [1:0] {TGT_WCR, TGT_WDRCR, TGT_WSICR} tgt_t;

    state_t             r_state;
    state_t             w_state_nxt;
    tgt_t               r_tgt;
    tgt_t               w_tgt;
    logic [1:0]         r_sclk_sync;
    logic [1:0]         r_cs_sync;
    logic [1:0]         r_mosi_sync;
    logic               r_sclk_prev;
    logic               r_cs_prev;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic [6:0]         r_cmd_sr;
    logic [SICR_W-1:0]  r_shadow;
    logic [DATA_W-1:0]  r_rd_sr;
    logic               r_miso;
    logic [WCR_W-1:0]   r_wcr;
    logic [15:0]        r_wdrcr;
    logic [SICR_W-1:0]  r_wsicr;
    logic [PER_W-1:0]   r_period_cnt;
    logic [DP_W-1:0]    r_drdy_cnt;
    logic               r_drdy_l;
    logic [15:0]        r_frame_cnt;
    logic               r_cfg_done;
    logic               r_proto_err;

    logic               w_sclk_rise;
    logic               w_cs_fall;
    logic               w_cs_rise;
    logic               w_mosi;
    logic [7:0]         w_cmd_byte;
    logic               w_go_wr;
    logic               w_go_rd;
    logic               w_bad_cmd;
    logic               w_commit;
    logic               w_short;
    logic [CNT_W-1:0]   w_wr_len;
    logic [DATA_W-1:0]  w_rd_img;
    logic [DATA_W-1:0]  w_data_img;

    assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_prev;
    assign w_cs_fall   = ~r_cs_sync[1] & r_cs_prev;
    assign w_cs_rise   = r_cs_sync[1] & ~r_cs_prev;
    assign w_mosi      = r_mosi_sync[1];
    assign w_cmd_byte  = {r_cmd_sr, w_mosi};

    assign MISO           = r_miso;
    assign DRDYOUT_l      = r_drdy_l;
    assign wcr_reg        = r_wcr;
    assign wdrcr_reg      = r_wdrcr;
    assign wsicr_reg      = r_wsicr;
    assign frame_cnt      = r_frame_cnt;
    assign cfg_wr_done_hp = r_cfg_done;
    assign proto_err_hp   = r_proto_err;

    // Bring the asynchronous SPI pins into the sys_clk domain and keep edge history.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_sclk_sync <= 2'b00;
            r_cs_sync   <= 2'b11;
            r_mosi_sync <= 2'b00;
            r_sclk_prev <= 1'b0;
            r_cs_prev   <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[0], SCLK};
            r_cs_sync   <= {r_cs_sync[0], CS_l};
            r_mosi_sync <= {r_mosi_sync[0], MOSI};
            r_sclk_prev <= r_sclk_sync[1];
            r_cs_prev   <= r_cs_sync[1];
        end
    end

    // Sample-data image: 24-bit word per channel, shut-down devices read as zero.
    always_comb begin
        w_data_img = {DATA_W{1'b0}};
        for (int d = 0; d < ADC_DCN; d++) begin
            for (int c = 0; c < 4; c++) begin
                if (!r_wcr[d*8+3]) begin
                    w_data_img[d*96 + c*24 +: 24] = {r_frame_cnt, 6'(d), 2'(c)};
                end else begin
                    w_data_img[d*96 + c*24 +: 24] = 24'h000000;
                end
            end
        end
    end

    // Payload length of the write currently in progress.
    always_comb begin
        w_wr_len = CNT_W'(16);
        case (r_tgt)
            TGT_WCR:   w_wr_len = CNT_W'(WCR_W);
            TGT_WDRCR: w_wr_len = CNT_W'(16);
            TGT_WSICR: w_wr_len = CNT_W'(SICR_W);
            default:   w_wr_len = CNT_W'(16);
        endcase
    end

    // Transfer FSM next state, command decode and end-of-transfer events.
    always_comb begin
        w_state_nxt = r_state;
        w_go_wr     = 1'b0;
        w_go_rd     = 1'b0;
        w_bad_cmd   = 1'b0;
        w_commit    = 1'b0;
        w_short     = 1'b0;
        w_tgt       = TGT_WDRCR;
        w_rd_img    = {DATA_W{1'b0}};
        case (r_state)
            ST_IDLE: begin
                if (w_cs_fall) w_state_nxt = ST_CMD;
                else           w_state_nxt = ST_IDLE;
            end
            ST_CMD: begin
                if (w_cs_rise) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_sclk_rise && (r_bit_cnt == CNT_W'(7))) begin
                    case (w_cmd_byte)
                        CMD_WCR: begin
                            w_state_nxt = ST_WR; w_go_wr = 1'b1; w_tgt = TGT_WCR;
                        end
                        CMD_WDRCR: begin
                            w_state_nxt = ST_WR; w_go_wr = 1'b1; w_tgt = TGT_WDRCR;
                        end
                        CMD_WSICR: begin
                            w_state_nxt = ST_WR; w_go_wr = 1'b1; w_tgt = TGT_WSICR;
                        end
                        CMD_RCR: begin
                            w_state_nxt = ST_RD; w_go_rd = 1'b1;
                            w_rd_img = {r_wcr, {(DATA_W-WCR_W){1'b0}}};
                        end
                        CMD_RDRCR: begin
                            w_state_nxt = ST_RD; w_go_rd = 1'b1;
                            w_rd_img = {r_wdrcr, {(DATA_W-16){1'b0}}};
                        end
                        CMD_RSICR: begin
                            w_state_nxt = ST_RD; w_go_rd = 1'b1;
                            w_rd_img = {r_wsicr, {(DATA_W-SICR_W){1'b0}}};
                        end
                        CMD_RDATA: begin
                            w_state_nxt = ST_RD; w_go_rd = 1'b1;
                            w_rd_img = w_data_img;
                        end
                        default: begin
                            w_state_nxt = ST_IGN; w_bad_cmd = 1'b1;
                        end
                    endcase
                end else begin
                    w_state_nxt = ST_CMD;
                end
            end
            ST_WR: begin
                if (w_cs_rise) begin
                    w_state_nxt = ST_IDLE;
                    if (r_bit_cnt >= w_wr_len) w_commit = 1'b1;
                    else                       w_short  = 1'b1;
                end else begin
                    w_state_nxt = ST_WR;
                end
            end
            ST_RD: begin
                if (w_cs_rise) w_state_nxt = ST_IDLE;
                else           w_state_nxt = ST_RD;
            end
            ST_IGN: begin
                if (w_cs_rise) w_state_nxt = ST_IGN == ST_IGN ? ST_IDLE : ST_IGN;
                else           w_state_nxt = ST_IGN;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Shift registers, bit counter and MISO driver.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_bit_cnt <= {CNT_W{1'b0}};
            r_cmd_sr  <= 7'h00;
            r_tgt     <= TGT_WDRCR;
            r_shadow  <= {SICR_W{1'b0}};
            r_rd_sr   <= {DATA_W{1'b0}};
            r_miso    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_bit_cnt <= {CNT_W{1'b0}};
                    r_cmd_sr  <= 7'h00;
                    r_miso    <= 1'b0;
                end
                ST_CMD: begin
                    if (w_sclk_rise) begin
                        r_cmd_sr  <= w_cmd_byte[6:0];
                        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                        if (w_go_wr) begin
                            r_bit_cnt <= {CNT_W{1'b0}};
                            r_tgt     <= w_tgt;
                            r_shadow  <= {SICR_W{1'b0}};
                        end
                        if (w_go_rd) begin
                            r_bit_cnt <= {CNT_W{1'b0}};
                            r_miso    <= w_rd_img[DATA_W-1];
                            r_rd_sr   <= {w_rd_img[DATA_W-2:0], 1'b0};
                        end
                    end
                end
                ST_WR: begin
                    if (w_sclk_rise && (r_bit_cnt < w_wr_len)) begin
                        r_shadow  <= {r_shadow[SICR_W-2:0], w_mosi};
                        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                    end
                end
                ST_RD: begin
                    if (w_sclk_rise) begin
                        r_miso  <= r_rd_sr[DATA_W-1];
                        r_rd_sr <= {r_rd_sr[DATA_W-2:0], 1'b0};
                    end
                end
                default: r_miso <= 1'b0;
            endcase
            if (w_cs_rise) r_miso <= 1'b0;
        end
    end

    // Configuration registers and the one-cycle status pulses.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_wcr       <= {WCR_W{1'b0}};
            r_wdrcr     <= 16'h0000;
            r_wsicr     <= {SICR_W{1'b0}};
            r_cfg_done  <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_cfg_done  <= w_commit;
            r_proto_err <= w_bad_cmd | w_short;
            if (w_commit) begin
                case (r_tgt)
                    TGT_WCR:   r_wcr   <= r_shadow[WCR_W-1:0];
                    TGT_WDRCR: r_wdrcr <= r_shadow[15:0];
                    TGT_WSICR: r_wsicr <= r_shadow;
                    default:   r_wdrcr <= r_wdrcr;
                endcase
            end
        end
    end

    // Sample period counter, frame counter and DRDYOUT_l pulse generation.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_period_cnt <= {PER_W{1'b0}};
            r_frame_cnt  <= 16'h0000;
            r_drdy_l     <= 1'b1;
            r_drdy_cnt   <= {DP_W{1'b0}};
        end else if (r_period_cnt == P_LAST) begin
            r_period_cnt <= {PER_W{1'b0}};
            r_frame_cnt  <= r_frame_cnt + 16'h0001;
            r_drdy_l     <= 1'b0;
            r_drdy_cnt   <= DP_LOAD;
        end else begin
            r_period_cnt <= r_period_cnt + PER_W'(1);
            if (r_drdy_cnt != {DP_W{1'b0}}) r_drdy_cnt <= r_drdy_cnt - DP_W'(1);
            else                            r_drdy_l   <= 1'b1;
        end
    end
endmodule

// File: tb/tb_adc_chain_max11040_spi_slave.sv
// Directed self-checking bench for the MAX11040 chain responder.
module tb_adc_chain_max11040_spi_slave;
    localparam int N   = 8;
    localparam int TXW = 776;

    logic            sys_clk = 1'b0;
    logic            sys_rst;
    logic            SCLK;
    logic            CS_l;
    logic            MOSI;
    logic            MISO;
    logic            DRDYOUT_l;
    logic [N*8-1:0]  wcr_reg;
    logic [15:0]     wdrcr_reg;
    logic [N*32-1:0] wsicr_reg;
    logic [15:0]     frame_cnt;
    logic            cfg_wr_done_hp;
    logic            proto_err_hp;

    int checks = 0;
    int errors = 0;
    int n_done = 0;
    int n_err  = 0;
    int cyc    = 0;

    adc_chain_max11040_spi_slave #(.ADC_DCN(N), .SAMPLE_PERIOD(5000), .DRDY_PULSE(16)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .SCLK(SCLK), .CS_l(CS_l), .MOSI(MOSI),
        .MISO(MISO), .DRDYOUT_l(DRDYOUT_l), .wcr_reg(wcr_reg), .wdrcr_reg(wdrcr_reg),
        .wsicr_reg(wsicr_reg), .frame_cnt(frame_cnt), .cfg_wr_done_hp(cfg_wr_done_hp),
        .proto_err_hp(proto_err_hp)
    );

    always #5 sys_clk = ~sys_clk;

    // Pulse counters and cycles since reset release.
    always @(posedge sys_clk) begin
        if (cfg_wr_done_hp) n_done <= n_done + 1;
        if (proto_err_hp)   n_err  <= n_err + 1;
        if (sys_rst) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    // Full SPI mode-0 transfer, MSB first, SCLK half period of 5 sys_clk cycles.
    task automatic spi_xfer(input int nbits, input logic [TXW-1:0] tx, output logic [TXW-1:0] rx);
        rx = {TXW{1'b0}};
        CS_l = 1'b0;
        wait_clk(5);
        for (int i = 0; i < nbits; i++) begin
            MOSI = tx[nbits-1-i];
            wait_clk(5);
            SCLK = 1'b1;
            rx[nbits-1-i] = MISO;
            wait_clk(5);
            SCLK = 1'b0;
        end
        wait_clk(5);
        CS_l = 1'b1;
        MOSI = 1'b0;
        wait_clk(6);
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        wait_clk(4);
        checks++;
        if (MISO !== 1'b0 || DRDYOUT_l !== 1'b1) begin
            errors++; $display("FAIL reset_pins: MISO=%b DRDYOUT_l=%b, required 0 and 1", MISO, DRDYOUT_l);
        end
        checks++;
        if (wcr_reg !== 64'h0 || wdrcr_reg !== 16'h0 || wsicr_reg !== 256'h0) begin
            errors++; $display("FAIL reset_regs: wcr=%h wdrcr=%h wsicr=%h, required all zero", wcr_reg, wdrcr_reg, wsicr_reg);
        end
        checks++;
        if (frame_cnt !== 16'h0 || cfg_wr_done_hp !== 1'b0 || proto_err_hp !== 1'b0) begin
            errors++; $display("FAIL reset_misc: frame_cnt=%h done=%b err=%b, required 0", frame_cnt, cfg_wr_done_hp, proto_err_hp);
        end
    endtask

    task automatic test_drdy_idle();
        int lows = 0;
        int first = -1;
        int second = -1;
        int miso_hi = 0;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        for (int k = 1; k <= 12000; k++) begin
            @(negedge sys_clk);
            if (DRDYOUT_l === 1'b0) begin
                lows++;
                if (first < 0) first = k;
                else if (second < 0 && k > first + 100) second = k;
            end
            if (MISO !== 1'b0) miso_hi++;
        end
        checks++;
        if (lows != 32) begin errors++; $display("FAIL drdy_low_cycles: got %0d, required 32", lows); end
        checks++;
        if (first != 5000) begin errors++; $display("FAIL drdy_first: got %0d, required 5000", first); end
        checks++;
        if (second != 10000) begin errors++; $display("FAIL drdy_second: got %0d, required 10000", second); end
        checks++;
        if (frame_cnt !== 16'd2) begin errors++; $display("FAIL frame_cnt_idle: got %0d, required 2", frame_cnt); end
        checks++;
        if (miso_hi != 0) begin errors++; $display("FAIL miso_idle: %0d high samples, required 0", miso_hi); end
        wait_clk(1);
    endtask

    task automatic test_wdrcr_write();
        logic [TXW-1:0] rx;
        int d0 = n_done;
        int e0 = n_err;
        spi_xfer(24, TXW'({8'h50, 16'h1234}), rx);
        checks++;
        if (wdrcr_reg !== 16'h1234) begin errors++; $display("FAIL wdrcr_value: got %h, required 1234", wdrcr_reg); end
        checks++;
        if (n_done - d0 != 1) begin errors++; $display("FAIL wdrcr_done_pulses: got %0d, required 1", n_done - d0); end
        checks++;
        if (n_err - e0 != 0) begin errors++; $display("FAIL wdrcr_err_pulses: got %0d, required 0", n_err - e0); end
    endtask

    task automatic test_wcr_readback();
        logic [TXW-1:0] rx;
        spi_xfer(72, TXW'({8'h60, 64'h0807060504030201}), rx);
        checks++;
        if (wcr_reg !== 64'h0807060504030201) begin errors++; $display("FAIL wcr_value: got %h, required 0807060504030201", wcr_reg); end
        spi_xfer(72, TXW'({8'hE0, 64'h0}), rx);
        checks++;
        if (rx[63:0] !== 64'h0807060504030201) begin errors++; $display("FAIL rcr_readback: got %h, required 0807060504030201", rx[63:0]); end
        checks++;
        if (rx[71:64] !== 8'h00) begin errors++; $display("FAIL rcr_cmd_phase_miso: got %h, required 00", rx[71:64]); end
    endtask

    task automatic test_wsicr_short();
        logic [TXW-1:0] rx;
        logic [255:0]   exp_sicr;
        int d0;
        int e0;
        for (int i = 0; i < N; i++) exp_sicr[i*32 +: 32] = 32'hA5000000 + 32'(i);
        spi_xfer(264, TXW'({8'h40, exp_sicr}), rx);
        checks++;
        if (wsicr_reg !== exp_sicr) begin errors++; $display("FAIL wsicr_value: got %h, required %h", wsicr_reg, exp_sicr); end
        d0 = n_done;
        e0 = n_err;
        spi_xfer(108, TXW'({8'h40, {100{1'b1}}}), rx);
        checks++;
        if (wsicr_reg !== exp_sicr) begin errors++; $display("FAIL wsicr_short_unchanged: got %h, required %h", wsicr_reg, exp_sicr); end
        checks++;
        if (n_err - e0 != 1) begin errors++; $display("FAIL short_err_pulses: got %0d, required 1", n_err - e0); end
        checks++;
        if (n_done - d0 != 0) begin errors++; $display("FAIL short_done_pulses: got %0d, required 0", n_done - d0); end
    endtask

    task automatic test_bad_cmd();
        logic [TXW-1:0] rx;
        int d0 = n_done;
        int e0 = n_err;
        spi_xfer(24, TXW'({8'h12, 16'hFFFF}), rx);
        checks++;
        if (n_err - e0 != 1) begin errors++; $display("FAIL badcmd_err_pulses: got %0d, required 1", n_err - e0); end
        checks++;
        if (n_done - d0 != 0) begin errors++; $display("FAIL badcmd_done_pulses: got %0d, required 0", n_done - d0); end
        checks++;
        if (wdrcr_reg !== 16'h1234 || wcr_reg !== 64'h0807060504030201) begin
            errors++; $display("FAIL badcmd_regs: wdrcr=%h wcr=%h, required 1234 and 0807060504030201", wdrcr_reg, wcr_reg);
        end
    endtask

    task automatic test_rdata_tick();
        logic [TXW-1:0] rx;
        logic [767:0]   exp_img;
        sys_rst = 1'b1;
        wait_clk(3);
        sys_rst = 1'b0;
        spi_xfer(72, TXW'({8'h60, 64'h0000000000080000}), rx);
        while (cyc < 15100) wait_clk(1);
        spi_xfer(776, {8'hF0, 768'h0}, rx);
        exp_img = {768{1'b0}};
        for (int d = 0; d < N; d++)
            for (int c = 0; c < 4; c++)
                if (d != 2) exp_img[d*96 + c*24 +: 24] = {16'd3, 6'(d), 2'(c)};
        checks++;
        if (rx[767:744] !== 24'h00031F) begin errors++; $display("FAIL rdata_dev7_ch3: got %h, required 00031F", rx[767:744]); end
        checks++;
        if (rx[2*96 +: 96] !== 96'h0) begin errors++; $display("FAIL rdata_dev2_shdn: got %h, required 0", rx[2*96 +: 96]); end
        checks++;
        if (rx[767:0] !== exp_img) begin errors++; $display("FAIL rdata_image: got %h, required %h", rx[767:0], exp_img); end
        checks++;
        if (rx[775:768] !== 8'h00) begin errors++; $display("FAIL rdata_cmd_phase_miso: got %h, required 00", rx[775:768]); end
        checks++;
        if (frame_cnt !== 16'd4) begin errors++; $display("FAIL rdata_tick_happened: frame_cnt=%0d, required 4", frame_cnt); end
    endtask

    task automatic test_reset_mid_wr();
        logic [TXW-1:0] rx;
        logic [TXW-1:0] tx;
        int d0;
        int e0;
        spi_xfer(24, TXW'({8'h50, 16'h5A5A}), rx);
        checks++;
        if (wdrcr_reg !== 16'h5A5A) begin errors++; $display("FAIL pre_reset_wdrcr: got %h, required 5A5A", wdrcr_reg); end
        tx = TXW'({8'h50, 16'hFFFF});
        CS_l = 1'b0;
        wait_clk(5);
        for (int i = 0; i < 12; i++) begin
            MOSI = tx[23-i];
            wait_clk(5);
            SCLK = 1'b1;
            wait_clk(5);
            SCLK = 1'b0;
        end
        sys_rst = 1'b1;
        wait_clk(3);
        checks++;
        if (wdrcr_reg !== 16'h0 || wcr_reg !== 64'h0 || frame_cnt !== 16'h0 || MISO !== 1'b0) begin
            errors++; $display("FAIL midwr_reset_clear: wdrcr=%h wcr=%h frame=%h miso=%b, required all zero", wdrcr_reg, wcr_reg, frame_cnt, MISO);
        end
        sys_rst = 1'b0;
        wait_clk(3);
        CS_l = 1'b1;
        MOSI = 1'b0;
        wait_clk(6);
        d0 = n_done;
        e0 = n_err;
        spi_xfer(24, TXW'({8'h50, 16'hBEEF}), rx);
        checks++;
        if (wdrcr_reg !== 16'hBEEF) begin errors++; $display("FAIL post_reset_wdrcr: got %h, required BEEF", wdrcr_reg); end
        checks++;
        if (n_done - d0 != 1 || n_err - e0 != 0) begin
            errors++; $display("FAIL post_reset_pulses: done=%0d err=%0d, required 1 and 0", n_done - d0, n_err - e0);
        end
    endtask

    initial begin
        sys_rst = 1'b1;
        SCLK    = 1'b0;
        CS_l    = 1'b1;
        MOSI    = 1'b0;
        test_reset();
        test_drdy_idle();
        test_wdrcr_write();
        test_wcr_readback();
        test_wsicr_short();
        test_bad_cmd();
        test_rdata_tick();
        test_reset_mid_wr();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
